hex_scan_controller: RTL and testbench
======================================

// Module: hex_scan_controller
// PURPOSE
//   Time-multiplexes one hex_decoder across NUM_DIGITS common-anode 7-seg digits.
//   Holds a shadow copy of the digit values and drives the decoder's 4-bit code input.
//   Registers the decoder's active-low segment output and strobes one digit per slot,
//   with ghost-blanking at each slot start. Sits between the display-data producer and the board pins.
// PARAMETERS
//   NUM_DIGITS  4      digits scanned per frame (>=2)
//   DIV         50000  clocks per digit slot (> BLANK_CYC)
//   BLANK_CYC   2      clocks at slot start with all anodes off (>=1)
// PORTS
//   clock       in   1             system clock, all state on rising edge
//   reset       in   1             asynchronous, active-high; one clock, no other clock domains
//   enable      in   1             1 = scan; 0 = display dark (IDLE)
//   load_valid  in   1             producer offers new frame data
//   load_ready  out  1             controller can accept; transfer when valid&ready
//   load_data   in   4*NUM_DIGITS  digit i value = load_data[4i+3:4i]
//   load_blank  in   NUM_DIGITS    1 = digit i forced dark
//   dec_code    out  4             to hex_decoder input c (registered)
//   dec_seg     in   7             from hex_decoder display (active-low, combinational)
//   seg_n       out  7             segment pins, active-low (registered)
//   an_n        out  NUM_DIGITS    digit anodes, active-low, at most one low (registered)
//   frame_done  out  1             1-cycle pulse on last cycle of last slot
// BEHAVIOUR
//   Reset (async): state=IDLE, an_n=all 1, seg_n=7'h7F, dec_code=0, frame_done=0,
//     load_ready=1, shadow values=0, shadow blank mask=all 1, pending=0, counters=0.
//   State machine: IDLE, BLANK, SHOW.
//     IDLE : an_n all 1, seg_n 7'h7F. enable=1 -> BLANK, digit=0, slot_cnt=0.
//     BLANK: slot_cnt 0..BLANK_CYC-1; an_n all 1; dec_code=shadow[digit].
//            slot_cnt==BLANK_CYC-1 -> SHOW.
//     SHOW : slot_cnt BLANK_CYC..DIV-1; an_n[digit]=0 unless blank[digit].
//            slot_cnt==DIV-1 -> BLANK, digit=digit+1; after digit NUM_DIGITS-1 wraps to 0.
//   Counters: slot_cnt width $clog2(DIV), digit width $clog2(NUM_DIGITS);
//     explicit compare-and-clear wrap, no reliance on natural overflow.
//   seg_n = registered dec_seg, so it lags dec_code by 1 clock; BLANK_CYC>=1 hides the lag.
//     seg_n=7'h7F whenever state!=SHOW or digit is blanked.
//   frame_done=1 exactly when state=SHOW, digit=NUM_DIGITS-1 and slot_cnt=DIV-1.
//   Load handshake:
//     IDLE: accepted load writes shadow regs directly; visible at next enable.
//     Scanning, no pending: accepted load goes to a pending reg; load_ready drops next cycle.
//       Pending copies into shadow at the frame wrap; load_ready returns 1 the cycle after.
//       Shadow never changes mid-frame.
//     Load accepted on the frame_done cycle writes shadow directly; used by the next frame.
//     load_data/load_blank are ignored when valid&ready is 0.
//   enable falling mid-frame: next cycle state=IDLE, an_n all 1, seg_n 7'h7F, counters 0.
//     Any pending load is applied to shadow; load_ready=1.
//     Re-enable always restarts at digit 0, slot_cnt 0.
//   Reset mid-frame or mid-handshake: all state to reset values; pending data discarded.
// TESTING (NUM_DIGITS=4, DIV=8, BLANK_CYC=2, real hex_decoder attached)
//   1 Reset, then load 16'hA810, blank 4'b0000, enable=1 -> digit0: cycles 0-1 an_n=4'b1111;
//     cycles 2-7 an_n=4'b1110, seg_n=7'h40. digit1 seg_n=7'h79, digit2 7'h00, digit3 7'h08.
//   2 Free-run 3 frames -> frame_done pulses every 32 clocks; an_n never shows more than one 0.
//   3 Mid-frame, load 16'h1111 -> load_ready=0 until wrap, current frame still 16'hA810.
//     Next frame shows 7'h79 on all digits.
//   4 load_blank=4'b0100 -> digit2 slot an_n=4'b1111, seg_n=7'h7F throughout.
//   5 enable=0 at digit1 slot_cnt=5 -> next cycle an_n=4'b1111, seg_n=7'h7F.
//     Re-enable restarts at digit0, slot_cnt 0.
//   6 Assert reset during SHOW with a pending load -> outputs immediately at reset values.
//     After release and enable, all digits dark (blank mask all 1).

Source files
------------

// File: rtl/hex_scan_controller.sv
`timescale 1ns/1ps
`default_nettype none
// hex_scan_controller: scans one hex decoder across NUM_DIGITS common-anode 7-seg digits,
// with ghost blanking at each slot start and a frame-synchronous load handshake.
// Revision: 1.0
module hex_scan_controller #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 50000,
  parameter int BLANK_CYC  = 2
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      enable_i,
  input  logic                      load_valid_i,
  output logic                      load_ready_o,
  input  logic [4*NUM_DIGITS-1:0]   load_data_i,
  input  logic [NUM_DIGITS-1:0]     load_blank_i,
  output logic [3:0]                dec_code_o,
  input  logic [6:0]                dec_seg_i,
  output logic [6:0]                seg_n_o,
  output logic [NUM_DIGITS-1:0]     an_n_o,
  output logic                      frame_done_o
);

  localparam int SW = $clog2(DIV);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(DIV - 1);
  localparam logic [SW-1:0] BLANK_LAST = SW'(BLANK_CYC - 1);
  localparam logic [DW-1:0] DIG_LAST   = DW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [SW-1:0]             slot_q, slot_d;
  logic [DW-1:0]             digit_q, digit_d;
  logic [4*NUM_DIGITS-1:0]   shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0]     shadow_blank_q, shadow_blank_d;
  logic [4*NUM_DIGITS-1:0]   pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]     pend_blank_q, pend_blank_d;
  logic                      pend_q, pend_d;
  logic [3:0]                dec_code_q, dec_code_d;
  logic [6:0]                seg_n_q, seg_n_d;
  logic [NUM_DIGITS-1:0]     an_n_q, an_n_d;
  logic                      accept;
  logic                      frame_end;

  assign accept       = load_valid_i & ~pend_q;
  assign frame_end    = (state_q == S_SHOW) && (digit_q == DIG_LAST) && (slot_q == SLOT_LAST);
  assign load_ready_o = ~pend_q;
  assign frame_done_o = frame_end;
  assign dec_code_o   = dec_code_q;
  assign seg_n_o      = seg_n_q;
  assign an_n_o       = an_n_q;

  always_comb begin
    state_d        = state_q;
    slot_d         = slot_q;
    digit_d        = digit_q;
    shadow_val_d   = shadow_val_q;
    shadow_blank_d = shadow_blank_q;
    pend_val_d     = pend_val_q;
    pend_blank_d   = pend_blank_q;
    pend_d         = pend_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shadow_val_d   = load_data_i;
          shadow_blank_d = load_blank_i;
        end
        if (enable_i) begin
          state_d = S_BLANK;
          slot_d  = '0;
          digit_d = '0;
        end
      end
      S_BLANK, S_SHOW: begin
        // Shadow only changes at a frame boundary or when scanning stops.
        if (!enable_i || frame_end) begin
          if (pend_q) begin
            shadow_val_d   = pend_val_q;
            shadow_blank_d = pend_blank_q;
            pend_d         = 1'b0;
          end else if (accept) begin
            shadow_val_d   = load_data_i;
            shadow_blank_d = load_blank_i;
          end
        end else if (accept) begin
          pend_val_d   = load_data_i;
          pend_blank_d = load_blank_i;
          pend_d       = 1'b1;
        end

        if (!enable_i) begin
          state_d = S_IDLE;
          slot_d  = '0;
          digit_d = '0;
        end else if (state_q == S_BLANK) begin
          slot_d = slot_q + SW'(1);
          if (slot_q == BLANK_LAST) begin
            state_d = S_SHOW;
          end
        end else if (slot_q == SLOT_LAST) begin
          state_d = S_BLANK;
          slot_d  = '0;
          digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + DW'(1);
        end else begin
          slot_d = slot_q + SW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        slot_d  = '0;
        digit_d = '0;
      end
    endcase
  end

  // Outputs are derived from next-state values so the registers line up with state_q.
  always_comb begin
    dec_code_d = '0;
    an_n_d     = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_d == DW'(i)) begin
        dec_code_d = shadow_val_d[4*i +: 4];
        if ((state_d == S_SHOW) && !shadow_blank_d[i]) begin
          an_n_d[i] = 1'b0;
        end
      end
    end
    seg_n_d = (an_n_d != '1) ? dec_seg_i : 7'h7F;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= S_IDLE;
      slot_q         <= '0;
      digit_q        <= '0;
      shadow_val_q   <= '0;
      shadow_blank_q <= '1;
      pend_val_q     <= '0;
      pend_blank_q   <= '0;
      pend_q         <= 1'b0;
      dec_code_q     <= 4'h0;
      seg_n_q        <= 7'h7F;
      an_n_q         <= '1;
    end else begin
      state_q        <= state_d;
      slot_q         <= slot_d;
      digit_q        <= digit_d;
      shadow_val_q   <= shadow_val_d;
      shadow_blank_q <= shadow_blank_d;
      pend_val_q     <= pend_val_d;
      pend_blank_q   <= pend_blank_d;
      pend_q         <= pend_d;
      dec_code_q     <= dec_code_d;
      seg_n_q        <= seg_n_d;
      an_n_q         <= an_n_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hex_scan_controller.sv
`timescale 1ns/1ps
`default_nettype none
// tb_hex_scan_controller: directed frames with a queue scoreboard checked once per clock.
// Revision: 1.0
module tb_hex_scan_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        lv;
  logic [15:0] ld;
  logic [3:0]  lb;
  logic        load_ready;
  logic [3:0]  dec_code;
  logic [6:0]  dec_seg;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame_done;

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] id;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        fd;
    logic        rdy;
    logic [3:0]  code;
    logic        code_chk;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [6:0] hexseg(input logic [3:0] v);
    case (v)
      4'h0: hexseg = 7'h40;  4'h1: hexseg = 7'h79;  4'h2: hexseg = 7'h24;  4'h3: hexseg = 7'h30;
      4'h4: hexseg = 7'h19;  4'h5: hexseg = 7'h12;  4'h6: hexseg = 7'h02;  4'h7: hexseg = 7'h78;
      4'h8: hexseg = 7'h00;  4'h9: hexseg = 7'h10;  4'hA: hexseg = 7'h08;  4'hB: hexseg = 7'h03;
      4'hC: hexseg = 7'h46;  4'hD: hexseg = 7'h21;  4'hE: hexseg = 7'h06;  default: hexseg = 7'h0E;
    endcase
  endfunction

  assign dec_seg = hexseg(dec_code);

  hex_scan_controller #(.NUM_DIGITS(4), .DIV(8), .BLANK_CYC(2)) dut (
    .clock_i      (clk),
    .reset_i      (rst),
    .enable_i     (en),
    .load_valid_i (lv),
    .load_ready_o (load_ready),
    .load_data_i  (ld),
    .load_blank_i (lb),
    .dec_code_o   (dec_code),
    .dec_seg_i    (dec_seg),
    .seg_n_o      (seg_n),
    .an_n_o       (an_n),
    .frame_done_o (frame_done)
  );

  task automatic chk(input string nm, input logic [15:0] id, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s id=%0d actual=%0h required=%0h", nm, id, act, req);
    end
  endtask

  // Monitor: every sampled cycle with an outstanding expectation is compared.
  always @(negedge clk) begin : mon
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("an_n", e.id, {12'h0, an_n}, {12'h0, e.an});
      chk("seg_n", e.id, {9'h0, seg_n}, {9'h0, e.seg});
      chk("frame_done", e.id, {15'h0, frame_done}, {15'h0, e.fd});
      chk("load_ready", e.id, {15'h0, load_ready}, {15'h0, e.rdy});
      chk("an_onehot", e.id, {15'h0, ($countones(~an_n) <= 1)}, 16'h1);
      if (e.code_chk) chk("dec_code", e.id, {12'h0, dec_code}, {12'h0, e.code});
    end
  end

  function automatic exp_t mk(input int id, input logic [3:0] an, input logic [6:0] seg,
                              input logic fd, input logic rdy, input logic [3:0] code, input logic cc);
    exp_t x;
    x.id = 16'(id); x.an = an; x.seg = seg; x.fd = fd; x.rdy = rdy; x.code = code; x.code_chk = cc;
    return x;
  endfunction

  task automatic step(input logic e_en, input logic e_lv, input logic [15:0] e_ld,
                      input logic [3:0] e_lb, input exp_t x);
    en = e_en; lv = e_lv; ld = e_ld; lb = e_lb;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // One frame of 4 digits x 8 clocks; optional load at cycle load_at, early exit at stop_at.
  task automatic run_frame(input int fid, input logic [15:0] data, input logic [3:0] blank,
                           input int load_at, input logic [15:0] ld_d, input logic [3:0] ld_b,
                           input int stop_at, input logic keep_en);
    logic rdy;
    rdy = 1'b1;
    for (int c = 0; c < 32; c++) begin
      int d;
      int s;
      logic lit;
      logic [3:0] nib;
      logic [3:0] onehot;
      d      = c / 8;
      s      = c % 8;
      lit    = (s >= 2) && !blank[d];
      nib    = data[4*d +: 4];
      onehot = 4'b0001 << d;
      step(keep_en || (c != stop_at), c == load_at, ld_d, ld_b,
           mk(fid * 64 + c, lit ? ~onehot : 4'hF, lit ? hexseg(nib) : 7'h7F,
              c == 31, rdy, nib, 1'b1));
      if (c == load_at) rdy = 1'b0;
      if (c == stop_at) break;
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog id=0 actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b0; lv = 1'b0; ld = 16'h0; lb = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    step(0, 0, 16'h0, 4'h0, mk(1, 4'hF, 7'h7F, 0, 1, 4'h0, 1));
    rst = 1'b0;
    step(0, 0, 16'h0, 4'h0, mk(2, 4'hF, 7'h7F, 0, 1, 4'h0, 1));
    step(0, 1, 16'hA810, 4'h0, mk(3, 4'hF, 7'h7F, 0, 1, 4'h0, 0));
    step(1, 0, 16'h0, 4'h0, mk(4, 4'hF, 7'h7F, 0, 1, 4'h0, 0));

    for (int f = 1; f <= 4; f++) run_frame(f, 16'hA810, 4'h0, -1, 16'h0, 4'h0, 99, 1);
    run_frame(5, 16'hA810, 4'h0, 10, 16'h1111, 4'h0, 99, 1);
    run_frame(6, 16'h1111, 4'h0, 5, 16'h1111, 4'b0100, 99, 1);
    run_frame(7, 16'h1111, 4'b0100, 3, 16'h3210, 4'h0, 13, 0);

    step(0, 0, 16'h0, 4'h0, mk(100, 4'hF, 7'h7F, 0, 1, 4'h0, 0));
    step(0, 0, 16'h0, 4'h0, mk(101, 4'hF, 7'h7F, 0, 1, 4'h0, 0));
    step(1, 0, 16'h0, 4'h0, mk(102, 4'hF, 7'h7F, 0, 1, 4'h0, 0));
    run_frame(8, 16'h3210, 4'h0, -1, 16'h0, 4'h0, 99, 1);
    run_frame(9, 16'h3210, 4'h0, 4, 16'hFFFF, 4'h0, 19, 1);

    rst = 1'b1;
    step(1, 0, 16'h0, 4'h0, mk(200, 4'hF, 7'h7F, 0, 1, 4'h0, 1));
    step(1, 0, 16'h0, 4'h0, mk(201, 4'hF, 7'h7F, 0, 1, 4'h0, 1));
    rst = 1'b0;
    step(1, 0, 16'h0, 4'h0, mk(202, 4'hF, 7'h7F, 0, 1, 4'h0, 1));
    run_frame(10, 16'h0000, 4'hF, -1, 16'h0, 4'h0, 99, 1);

    en = 1'b0;
    @(negedge clk);
    chk("queue_drain", 16'd999, 16'(exp_q.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
